// File: rtl/lockpick_game_param.sv
// rtl/lockpick_game_param.sv - parametrised lockpick game core: two keys in, S-box hash, compare, result message out
module lockpick_game_param #(
  parameter int KEY_BYTES      = 32,
  parameter int ROUNDS         = 3,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter logic [8*KEY_BYTES-1:0] TARGET_INIT = {KEY_BYTES/4{32'hCAFEBABE}},
  localparam int AW = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          input_enable,
  input  logic          target_load,
  input  logic [7:0]    input_data,
  output logic          output_valid,
  output logic [7:0]    output_data,
  output logic [1:0]    status,
  output logic [AW-1:0] attempts_left,
  output logic          busy
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int CW = $clog2(KEY_BYTES);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(KEY_BYTES - 1);
  localparam logic [LW-1:0] LAST_LOCK = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_ROUND = 8'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  // AES S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    S_IDLE, S_INPUT_A, S_INPUT_B, S_HASH, S_COMPARE, S_OUTPUT, S_LOCKED
  } state_t;

  state_t         state;
  logic [KW-1:0]  key_a;
  logic [KW-1:0]  key_b;
  logic [KW-1:0]  s_reg;
  logic [KW-1:0]  target;
  logic [KW-1:0]  hash_in;
  logic [CW-1:0]  byte_cnt;
  logic [CW-1:0]  tgt_idx;
  logic [CW-1:0]  out_cnt;
  logic [7:0]     round_cnt;
  logic [LW-1:0]  lock_cnt;
  logic [AW-1:0]  fail_count;
  logic [31:0]    pattern;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // 255 - x selects the entry counted from the MSB end
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  // One round: substitute each byte mixed with its rotated neighbour, then rotate the vector by one byte
  function automatic logic [KW-1:0] hash_round(input logic [KW-1:0] s, input logic [7:0] r);
    logic [KW-1:0] res;
    logic [7:0]    nb;
    res = '0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      nb = s[8*((i+1) % KEY_BYTES) +: 8];
      res[8*((i+1) % KEY_BYTES) +: 8] = sbox(s[8*i +: 8] ^ {nb[6:0], nb[7]} ^ r);
    end
    return res;
  endfunction

  // Round 0 starts from the XOR of the two keys, later rounds chain on the state register
  always_comb begin
    hash_in = s_reg;
    if (round_cnt == 8'd0) hash_in = key_a ^ key_b;
  end

  assign attempts_left = AW'(MAX_ATTEMPTS) - fail_count;
  assign busy          = (state != S_IDLE);

  // Game FSM with registered status and message outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      key_a        <= '0;
      key_b        <= '0;
      s_reg        <= '0;
      target       <= TARGET_INIT;
      byte_cnt     <= '0;
      tgt_idx      <= '0;
      out_cnt      <= '0;
      round_cnt    <= '0;
      lock_cnt     <= '0;
      fail_count   <= '0;
      pattern      <= '0;
      status       <= ST_IDLE;
      output_valid <= 1'b0;
      output_data  <= 8'h00;
    end else begin
      output_valid <= 1'b0;
      output_data  <= 8'h00;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_INPUT_A;
            byte_cnt <= '0;
            tgt_idx  <= '0;
            status   <= ST_IDLE;
          end else if (target_load && input_enable) begin
            target[{tgt_idx, 3'b000} +: 8] <= input_data;
            tgt_idx <= tgt_idx + 1'b1;
          end
        end
        S_INPUT_A: begin
          if (input_enable) begin
            key_a[{byte_cnt, 3'b000} +: 8] <= input_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) state <= S_INPUT_B;
          end
        end
        S_INPUT_B: begin
          if (input_enable) begin
            key_b[{byte_cnt, 3'b000} +: 8] <= input_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              state     <= S_HASH;
              round_cnt <= 8'd0;
            end
          end
        end
        S_HASH: begin
          s_reg     <= hash_round(hash_in, round_cnt);
          round_cnt <= round_cnt + 8'd1;
          if (round_cnt == LAST_ROUND) state <= S_COMPARE;
        end
        S_COMPARE: begin
          state   <= S_OUTPUT;
          out_cnt <= '0;
          if (s_reg == target) begin
            status  <= ST_WIN;
            pattern <= 32'hFACEFACE;
          end else begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == AW'(MAX_ATTEMPTS - 1)) begin
              status  <= ST_LOCK;
              pattern <= 32'hDEADDEAD;
            end else begin
              status  <= ST_ERR;
              pattern <= 32'hBAD0BAD0;
            end
          end
        end
        S_OUTPUT: begin
          output_valid <= 1'b1;
          output_data  <= pattern[{out_cnt[1:0], 3'b000} +: 8];
          out_cnt      <= out_cnt + 1'b1;
          if (out_cnt == LAST_BYTE) begin
            case (status)
              ST_WIN: begin
                state      <= S_IDLE;
                fail_count <= '0;
              end
              ST_LOCK: begin
                state    <= S_LOCKED;
                lock_cnt <= '0;
              end
              default: begin
                state    <= S_INPUT_A;
                byte_cnt <= '0;
              end
            endcase
          end
        end
        S_LOCKED: begin
          lock_cnt <= lock_cnt + 1'b1;
          if (lock_cnt == LAST_LOCK) begin
            state      <= S_IDLE;
            fail_count <= '0;
            status     <= ST_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lockpick_game_param.sv
// tb/tb_lockpick_game_param.sv - directed bench for lockpick_game_param with an independent hash model
module tb_lockpick_game_param;

  localparam int KB = 16;
  localparam int RN = 3;
  localparam int MA = 3;
  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       input_enable;
  logic       target_load;
  logic [7:0] input_data;
  logic       output_valid;
  logic [7:0] output_data;
  logic [1:0] status;
  logic [1:0] attempts_left;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  logic [8*KB-1:0] zero_key, wa, wb, xa, xb, gw, gx;

  lockpick_game_param #(
    .KEY_BYTES(KB), .ROUNDS(RN), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .input_enable(input_enable),
    .target_load(target_load), .input_data(input_data),
    .output_valid(output_valid), .output_data(output_data),
    .status(status), .attempts_left(attempts_left), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box built from the GF(2^8) inverse and the affine map, not from a table
  task automatic build_sbox();
    logic [7:0] inv, yv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yv = 8'(y);
        if (gmul(8'(x), yv) == 8'h01) inv = yv;
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [8*KB-1:0] hash_model(input logic [8*KB-1:0] a, input logic [8*KB-1:0] b);
    logic [7:0] s [KB];
    logic [7:0] t [KB];
    logic [7:0] nb;
    logic [8*KB-1:0] res;
    for (int i = 0; i < KB; i++) s[i] = a[8*i +: 8] ^ b[8*i +: 8];
    for (int r = 0; r < RN; r++) begin
      for (int i = 0; i < KB; i++) begin
        nb   = s[(i+1) % KB];
        t[i] = sb[s[i] ^ {nb[6:0], nb[7]} ^ 8'(r)];
      end
      for (int i = 0; i < KB; i++) s[(i+1) % KB] = t[i];
    end
    for (int i = 0; i < KB; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; input_enable = 1'b0; target_load = 1'b0; input_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_status"}, status, 2'b00);
    check({tag, "_valid"}, output_valid, 1'b0);
    check({tag, "_data"}, output_data, 8'h00);
    check({tag, "_attempts"}, attempts_left, 2'd3);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Writes the first n target bytes, with an idle target_load cycle sprinkled in
  task automatic load_bytes(input logic [8*KB-1:0] tg, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 2) begin
        target_load = 1'b1; input_enable = 1'b0; input_data = 8'hEE;
        @(negedge clk);
      end
      target_load = 1'b1; input_enable = 1'b1; input_data = tg[8*i +: 8];
      @(negedge clk);
    end
    target_load = 1'b0; input_enable = 1'b0;
  endtask

  task automatic send_key(input logic [8*KB-1:0] k, input int maxgap);
    int gap;
    for (int i = 0; i < KB; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) begin
        target_load  = (maxgap > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        input_enable = 1'b0;
        input_data   = 8'($urandom);
        @(negedge clk);
      end
      target_load  = (maxgap > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      input_enable = 1'b1;
      input_data   = k[8*i +: 8];
      @(negedge clk);
    end
    input_enable = 1'b0;
    target_load  = 1'b0;
  endtask

  task automatic play(input logic [8*KB-1:0] a, input logic [8*KB-1:0] b, input int maxgap);
    send_key(a, maxgap);
    send_key(b, maxgap);
  endtask

  // Entered on the first negedge after the last B byte; leaves on the negedge showing the last message byte
  task automatic collect(input logic [31:0] pat, input logic [1:0] exp_st, input logic [1:0] exp_at);
    int j;
    logic [1:0] st_o, at_o;
    st_o = 'x;
    at_o = 'x;
    j = 1;
    while (j < 60 && !output_valid) begin
      if (j == RN + 2) begin
        st_o = status;
        at_o = attempts_left;
      end
      @(negedge clk);
      j++;
    end
    check("first_valid_latency", j, RN + 3);
    check("status_at_output", st_o, exp_st);
    check("attempts_at_output", at_o, exp_at);
    for (int k = 0; k < KB; k++) begin
      if (k > 0) @(negedge clk);
      check("out_byte", {output_valid, output_data}, {1'b1, pat[8*(k % 4) +: 8]});
    end
  endtask

  initial begin
    int j;
    rst = 1'b1; start = 1'b0; input_enable = 1'b0; target_load = 1'b0; input_data = 8'h00;
    build_sbox();
    zero_key = '0;
    for (int i = 0; i < KB; i++) begin
      wa[8*i +: 8] = 8'(i);
      wb[8*i +: 8] = 8'hFF;
      xa[8*i +: 8] = 8'(8'hA0 + i);
      xb[8*i +: 8] = 8'(3 * i);
    end
    gw = hash_model(wa, wb);
    gx = hash_model(xa, xb);

    // Reset state and lockout sequence
    reset_dut();
    check_reset_values("reset");
    do_start();
    play(zero_key, zero_key, 0);
    collect(32'hBAD0BAD0, 2'b01, 2'd2);
    check("busy_after_error", busy, 1'b1);
    play(zero_key, zero_key, 0);
    collect(32'hBAD0BAD0, 2'b01, 2'd1);
    play(zero_key, zero_key, 0);
    collect(32'hDEADDEAD, 2'b11, 2'd0);
    check("locked_busy_0", busy, 1'b1);
    for (int c = 1; c < LC; c++) begin
      if (c == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check("valid_drop_after_msg", {output_valid, output_data}, 9'h000);
      check("locked_busy", busy, 1'b1);
      check("locked_status", status, 2'b11);
    end
    @(negedge clk);
    check("unlock_busy", busy, 1'b0);
    check("unlock_status", status, 2'b00);
    check("unlock_attempts", attempts_left, 2'd3);
    do_start();
    check("start_after_unlock_status", status, 2'b00);

    // Programmed target: one miss, then a win that restores attempts
    reset_dut();
    load_bytes(gw, KB);
    do_start();
    play(zero_key, zero_key, 0);
    collect(32'hBAD0BAD0, 2'b01, 2'd2);
    play(wa, wb, 0);
    collect(32'hFACEFACE, 2'b10, 2'd2);
    @(negedge clk);
    check("win_idle_busy", busy, 1'b0);
    check("win_attempts", attempts_left, 2'd3);
    check("win_status_held", status, 2'b10);

    // Gapped input with target_load noise gives the same hash
    do_start();
    check("start_clears_status", status, 2'b00);
    play(wa, wb, 5);
    collect(32'hFACEFACE, 2'b10, 2'd3);
    @(negedge clk);

    // start wins over a simultaneous target write, and tgt_idx restarts
    load_bytes(gw, 3);
    start = 1'b1; target_load = 1'b1; input_enable = 1'b1; input_data = 8'h55;
    @(negedge clk);
    start = 1'b0; target_load = 1'b0; input_enable = 1'b0;
    check("start_over_target_busy", busy, 1'b1);
    play(wa, wb, 0);
    collect(32'hFACEFACE, 2'b10, 2'd3);
    @(negedge clk);
    load_bytes(gx, KB);
    do_start();
    play(xa, xb, 0);
    collect(32'hFACEFACE, 2'b10, 2'd3);
    @(negedge clk);

    // Reset mid-HASH
    reset_dut();
    load_bytes(gw, KB);
    do_start();
    play(wa, wb, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_hash");
    rst = 1'b0;

    // Reset mid-OUTPUT, then the target is back to its initial value
    load_bytes(gw, KB);
    do_start();
    play(wa, wb, 0);
    j = 0;
    while (j < 60 && !output_valid) begin
      @(negedge clk);
      j++;
    end
    check("rst_out_reached_output", output_valid, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_output");
    rst = 1'b0;
    do_start();
    play(wa, wb, 0);
    collect(32'hBAD0BAD0, 2'b01, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
